parking_lot_ctrl: RTL

Parametrised, clocked parking-lot controller: tracks occupancy of NUM_SLOTS bays, allocates the lowest free bay to arriving vehicles, and ages each occupied bay on an hour tick. On departure it frees the bay and computes the bill (duration × rate) with an iterative multiplier. It sits between the entry/exit gate logic and the billing display, and replaces the combinational free-lot/subtract/multiply chain.

---
 rtl/parking_lot_ctrl_pkg.sv | 17 +
 rtl/parking_lot_ctrl_if.sv | 48 ++++
 rtl/parking_lot_ctrl_mult.sv | 54 +++++
 rtl/parking_lot_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/parking_lot_ctrl_pkg.sv
// Shared types and width helpers for the parking-lot controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } bill_state_e;

  // Bay index width; a single-bit index is the minimum even for tiny lots.
  function automatic int slot_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/parking_lot_ctrl_if.sv
// Gate/billing-side signal bundle for parking_lot_ctrl; the master drives the
// gate events, the slave (controller) drives status and billing results.
interface parking_lot_ctrl_if #(
  parameter int NUM_SLOTS = 4,
  parameter int TIME_W    = 4,
  parameter int RATE_W    = 4
) ();
  localparam int SLOT_W = parking_pkg::slot_w(NUM_SLOTS);
  localparam int COST_W = TIME_W + RATE_W;
  localparam int OCC_W  = $clog2(NUM_SLOTS + 1);

  // Handshakes: an arrival/departure is taken on a rising clk edge where its
  // valid and ready are both high; ready never depends on the same-cycle valid.
  logic                  tick;
  logic                  arrive_valid;
  logic                  arrive_ready;
  logic [SLOT_W-1:0]     alloc_slot;
  logic                  depart_valid;
  logic [SLOT_W-1:0]     depart_slot;
  logic                  depart_ready;
  logic [RATE_W-1:0]     rate;
  logic                  depart_err;
  logic                  bill_valid;
  logic [SLOT_W-1:0]     bill_slot;
  logic [TIME_W-1:0]     bill_entry;
  logic [TIME_W-1:0]     bill_duration;
  logic [COST_W-1:0]     bill_cost;
  logic [NUM_SLOTS-1:0]  slot_busy;
  logic [OCC_W-1:0]      occupancy;
  logic                  full;
  logic                  empty;
  logic [TIME_W-1:0]     now;
  parking_pkg::bill_state_e bill_state;

  modport master (
    output tick, arrive_valid, depart_valid, depart_slot, rate,
    input  arrive_ready, alloc_slot, depart_ready, depart_err, bill_valid,
           bill_slot, bill_entry, bill_duration, bill_cost, slot_busy,
           occupancy, full, empty, now, bill_state
  );

  modport slave (
    input  tick, arrive_valid, depart_valid, depart_slot, rate,
    output arrive_ready, alloc_slot, depart_ready, depart_err, bill_valid,
           bill_slot, bill_entry, bill_duration, bill_cost, slot_busy,
           occupancy, full, empty, now, bill_state
  );
endinterface

// File: rtl/parking_lot_ctrl_mult.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, TIME_W steps,
// single-cycle done pulse after the last step.
module parking_cost_mult #(
  parameter int TIME_W = 4,
  parameter int RATE_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [RATE_W-1:0]          mcand_i,
  input  logic [TIME_W-1:0]          mplier_i,
  output logic                       done_o,
  output logic [TIME_W+RATE_W-1:0]   product_o
);
  localparam int COST_W = TIME_W + RATE_W;
  localparam int CNT_W  = $clog2(TIME_W + 1);

  logic [COST_W-1:0] mcand_q, acc_q;
  logic [TIME_W-1:0] mplier_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              run_q, done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        mcand_q  <= COST_W'(mcand_i);
        mplier_q <= mplier_i;
        acc_q    <= '0;
        cnt_q    <= '0;
        run_q    <= 1'b1;
      end else if (run_q) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(TIME_W - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;
endmodule

// File: rtl/parking_lot_ctrl.sv
// Parking-lot controller: bay allocation, hourly ageing and sequential billing.
// Optional macro PARKING_MIN_CHARGE_EN bills a zero-hour stay as one hour.
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int TIME_W    = 4,
  parameter int RATE_W    = 4
) (
  input logic               clk,
  input logic               rst_n,
  parking_lot_ctrl_if.slave pl
);
  localparam int SLOT_W = slot_w(NUM_SLOTS);
  localparam int COST_W = TIME_W + RATE_W;
  localparam int OCC_W  = $clog2(NUM_SLOTS + 1);
  localparam logic [TIME_W-1:0] DUR_MAX = '1;

  logic [NUM_SLOTS-1:0] busy_q;
  logic [TIME_W-1:0]    entry_q [NUM_SLOTS];
  logic [TIME_W-1:0]    dur_q   [NUM_SLOTS];
  logic [TIME_W-1:0]    now_q;
  logic [OCC_W-1:0]     occ_q;

  bill_state_e          state_q;
  logic                 bill_valid_q, err_q;
  logic [SLOT_W-1:0]    bslot_q, bill_slot_q;
  logic [TIME_W-1:0]    bentry_q, bdur_q, bill_entry_q, bill_dur_q;
  logic [COST_W-1:0]    bill_cost_q;

  logic                 full, arr_acc, dep_ok, slot_hit, dep_hit, mul_done;
  logic [SLOT_W-1:0]    alloc;
  logic [TIME_W-1:0]    sel_entry, sel_dur, mul_op;
  logic [COST_W-1:0]    mul_prod;

  always_comb begin
    alloc = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!busy_q[i]) alloc = SLOT_W'(i);
  end

  assign full    = (occ_q == OCC_W'(NUM_SLOTS));
  assign arr_acc = pl.arrive_valid && !full;
  assign dep_ok  = (state_q == IDLE);

  // Out-of-range bay numbers never match, so they read as an empty bay.
  always_comb begin
    slot_hit  = 1'b0;
    sel_entry = '0;
    sel_dur   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (pl.depart_slot == SLOT_W'(i)) begin
        slot_hit  = busy_q[i];
        sel_entry = entry_q[i];
        sel_dur   = dur_q[i];
      end
    end
  end
  assign dep_hit = pl.depart_valid && dep_ok && slot_hit;

`ifdef PARKING_MIN_CHARGE_EN
  assign mul_op = (sel_dur == '0) ? TIME_W'(1) : sel_dur;
`else
  assign mul_op = sel_dur;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      now_q  <= '0;
      occ_q  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        entry_q[i] <= '0;
        dur_q[i]   <= '0;
      end
    end else begin
      if (pl.tick) now_q <= now_q + 1'b1;
      occ_q <= occ_q + OCC_W'(arr_acc) - OCC_W'(dep_hit);
      // Arrival overrides a coincident tick so a fresh bay starts at zero.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (pl.tick && busy_q[i] && dur_q[i] != DUR_MAX) dur_q[i] <= dur_q[i] + 1'b1;
        if (arr_acc && alloc == SLOT_W'(i)) begin
          busy_q[i]  <= 1'b1;
          entry_q[i] <= now_q;
          dur_q[i]   <= '0;
        end
        if (dep_hit && pl.depart_slot == SLOT_W'(i)) busy_q[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bill_valid_q <= 1'b0;
      err_q        <= 1'b0;
      bslot_q      <= '0;
      bentry_q     <= '0;
      bdur_q       <= '0;
      bill_slot_q  <= '0;
      bill_entry_q <= '0;
      bill_dur_q   <= '0;
      bill_cost_q  <= '0;
    end else begin
      err_q        <= pl.depart_valid && dep_ok && !slot_hit;
      bill_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (dep_hit) begin
          state_q  <= MUL;
          bslot_q  <= pl.depart_slot;
          bentry_q <= sel_entry;
          bdur_q   <= sel_dur;
        end
        MUL: if (mul_done) begin
          state_q      <= DONE;
          bill_valid_q <= 1'b1;
          bill_slot_q  <= bslot_q;
          bill_entry_q <= bentry_q;
          bill_dur_q   <= bdur_q;
          bill_cost_q  <= mul_prod;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  parking_cost_mult #(.TIME_W(TIME_W), .RATE_W(RATE_W)) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (dep_hit),
    .mcand_i   (pl.rate),
    .mplier_i  (mul_op),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  assign pl.arrive_ready  = !full;
  assign pl.alloc_slot    = alloc;
  assign pl.depart_ready  = dep_ok;
  assign pl.depart_err    = err_q;
  assign pl.bill_valid    = bill_valid_q;
  assign pl.bill_slot     = bill_slot_q;
  assign pl.bill_entry    = bill_entry_q;
  assign pl.bill_duration = bill_dur_q;
  assign pl.bill_cost     = bill_cost_q;
  assign pl.slot_busy     = busy_q;
  assign pl.occupancy     = occ_q;
  assign pl.full          = full;
  assign pl.empty         = (occ_q == '0);
  assign pl.now           = now_q;
  assign pl.bill_state    = state_q;
endmodule
